// File: rtl/fetch_pc_redirect_pkg.sv
// Shared processor definitions for the fetch stage: reset PC, NOP encoding,
// and the redirect FSM state encoding.
package fetch_pc_redirect_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] NOP              = 32'b0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_pc_redirect_if.sv
// Fetch-side bundle: execute redirect request and stall controls in,
// PC / latch controls / debug state out.
interface fetch_pc_redirect_if #(
  parameter int CNT_W = 16
);
  import fetch_pc_redirect_pkg::*;

  // select_execute_Next_PC is a one-cycle request qualified by the stalls:
  // it is consumed at the edge where it is high unless stall_all freezes the
  // pipe, in which case the target is parked until stall_all drops.
  logic [31:0]      execute_Next_PC;
  logic             select_execute_Next_PC;
  logic             stall_fetch;
  logic             stall_all;
  logic [31:0]      address_imem;
  logic [31:0]      fd_pc_plus_one;
  logic             flush_FD;
  logic             flush_DX;
  logic             pc_write_enable;
  logic [CNT_W-1:0] redirect_count;
  state_t           state;

  modport master (
    output execute_Next_PC, select_execute_Next_PC, stall_fetch, stall_all,
    input  address_imem, fd_pc_plus_one, flush_FD, flush_DX,
           pc_write_enable, redirect_count, state
  );

  modport slave (
    input  execute_Next_PC, select_execute_Next_PC, stall_fetch, stall_all,
    output address_imem, fd_pc_plus_one, flush_FD, flush_DX,
           pc_write_enable, redirect_count, state
  );

endinterface

// File: rtl/register_32.sv
// 32-bit register with write enable; synchronous reset loads RESET_VALUE.
module register_32 #(
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (write_enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_redirect.sv
// Program counter owner: applies execute redirects, squashes F/D and D/X,
// parks a redirect across a full-pipeline freeze, counts redirects.
module fetch_pc_redirect
  import fetch_pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  fetch_pc_redirect_if.slave   bus
);

  state_t           state, next_state;
  logic [31:0]      pc, pc_d, pending;
  logic             pc_we, pending_we;
  logic             flush_fd, flush_dx, cnt_inc;
  logic [CNT_W-1:0] cnt;

  register_32 #(.RESET_VALUE(RESET_PC)) u_pc (
    .clock        (clock),
    .reset        (reset),
    .write_enable (pc_we),
    .d            (pc_d),
    .q            (pc)
  );

  register_32 #(.RESET_VALUE(32'd0)) u_pending (
    .clock        (clock),
    .reset        (reset),
    .write_enable (pending_we),
    .d            (bus.execute_Next_PC),
    .q            (pending)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_d       = pc + 32'd1;
    pc_we      = 1'b0;
    pending_we = 1'b0;
    flush_fd   = 1'b0;
    flush_dx   = 1'b0;
    cnt_inc    = 1'b0;
    if (reset) begin
      flush_fd = 1'b1;
      flush_dx = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.stall_all) begin
            if (bus.select_execute_Next_PC) begin
              pending_we = 1'b1;
              next_state = HOLD;
            end
          end else if (bus.select_execute_Next_PC) begin
            pc_d     = bus.execute_Next_PC;
            pc_we    = 1'b1;
            flush_fd = 1'b1;
            flush_dx = 1'b1;
            cnt_inc  = 1'b1;
          end else if (bus.stall_fetch) begin
            flush_dx = 1'b1;
          end else begin
            pc_we = 1'b1;
          end
        end
        HOLD: begin
          // The live select is the same frozen instruction already parked.
          if (!bus.stall_all) begin
            pc_d       = pending;
            pc_we      = 1'b1;
            flush_fd   = 1'b1;
            flush_dx   = 1'b1;
            cnt_inc    = 1'b1;
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.address_imem    = pc;
  assign bus.fd_pc_plus_one  = pc + 32'd1;
  assign bus.flush_FD        = flush_fd;
  assign bus.flush_DX        = flush_dx;
  assign bus.pc_write_enable = pc_we;
  assign bus.redirect_count  = cnt;
  assign bus.state           = state;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Directed bench for fetch_pc_redirect: a driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_fetch_pc_redirect;
  import fetch_pc_redirect_pkg::*;

  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0]      addr;
    logic             ffd;
    logic             fdx;
    logic             we;
    logic [CNT_W-1:0] cnt;
    logic             st;
  } exp_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q[$];

  fetch_pc_redirect_if #(.CNT_W(CNT_W)) bus ();

  fetch_pc_redirect #(.RESET_PC(32'd0), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("address_imem",    bus.address_imem,              e.addr);
      check("fd_pc_plus_one",  bus.fd_pc_plus_one,            e.addr + 32'd1);
      check("flush_FD",        {31'd0, bus.flush_FD},         {31'd0, e.ffd});
      check("flush_DX",        {31'd0, bus.flush_DX},         {31'd0, e.fdx});
      check("pc_write_enable", {31'd0, bus.pc_write_enable},  {31'd0, e.we});
      check("redirect_count",  {29'd0, bus.redirect_count},   {29'd0, e.cnt});
      check("state",           {31'd0, bus.state},            {31'd0, e.st});
    end
  end

  // driver: apply one cycle of inputs and push the expected outputs for it
  task automatic step(input logic rst, input logic sel, input logic [31:0] tgt,
                      input logic sf, input logic sa,
                      input logic [31:0] e_addr, input logic e_ffd, input logic e_fdx,
                      input logic e_we, input logic [CNT_W-1:0] e_cnt, input logic e_st);
    exp_t e;
    reset                      = rst;
    bus.select_execute_Next_PC = sel;
    bus.execute_Next_PC        = tgt;
    bus.stall_fetch            = sf;
    bus.stall_all              = sa;
    e.addr = e_addr; e.ffd = e_ffd; e.fdx = e_fdx;
    e.we   = e_we;   e.cnt = e_cnt; e.st  = e_st;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.select_execute_Next_PC = 1'b0;
    bus.execute_Next_PC        = 32'd0;
    bus.stall_fetch            = 1'b0;
    bus.stall_all              = 1'b0;
    @(posedge clock);
    #1;
    //   rst sel tgt           sf sa  addr          ffd fdx we cnt st
    step(1, 0, 32'h0,          0, 0,  32'h0,        1,  1,  0, 0, RUN);
    // free run
    step(0, 0, 32'h0,          0, 0,  32'h0,        0,  0,  1, 0, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h1,        0,  0,  1, 0, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h2,        0,  0,  1, 0, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h3,        0,  0,  1, 0, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h4,        0,  0,  1, 0, RUN);
    // redirect at PC=5 to 0x40, then to 7
    step(0, 1, 32'h40,         0, 0,  32'h5,        1,  1,  1, 0, RUN);
    step(0, 1, 32'h7,          0, 0,  32'h40,       1,  1,  1, 1, RUN);
    // load-use stall for two cycles at PC=7
    step(0, 0, 32'h0,          1, 0,  32'h7,        0,  1,  0, 2, RUN);
    step(0, 0, 32'h0,          1, 0,  32'h7,        0,  1,  0, 2, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h7,        0,  0,  1, 2, RUN);
    // redirect beats stall_fetch
    step(0, 1, 32'h10,         1, 0,  32'h8,        1,  1,  1, 2, RUN);
    // full freeze with a redirect; later redirect during HOLD ignored
    step(0, 1, 32'h80,         0, 1,  32'h10,       0,  0,  0, 3, RUN);
    step(0, 1, 32'h99,         0, 1,  32'h10,       0,  0,  0, 3, HOLD);
    step(0, 0, 32'h0,          0, 1,  32'h10,       0,  0,  0, 3, HOLD);
    step(0, 1, 32'h99,         0, 0,  32'h10,       1,  1,  1, 3, HOLD);
    // five back-to-back redirects, counter saturates at 7
    step(0, 1, 32'h20,         0, 0,  32'h80,       1,  1,  1, 4, RUN);
    step(0, 1, 32'h21,         0, 0,  32'h20,       1,  1,  1, 5, RUN);
    step(0, 1, 32'h22,         0, 0,  32'h21,       1,  1,  1, 6, RUN);
    step(0, 1, 32'h23,         0, 0,  32'h22,       1,  1,  1, 7, RUN);
    step(0, 1, 32'h24,         0, 0,  32'h23,       1,  1,  1, 7, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h24,       0,  0,  1, 7, RUN);
    // park a redirect, then reset while in HOLD
    step(0, 1, 32'h55,         0, 1,  32'h25,       0,  0,  0, 7, RUN);
    step(0, 0, 32'h0,          0, 1,  32'h25,       0,  0,  0, 7, HOLD);
    step(1, 0, 32'h0,          0, 1,  32'h25,       1,  1,  0, 7, HOLD);
    step(0, 0, 32'h0,          0, 0,  32'h0,        0,  0,  1, 0, RUN);
    // PC wraparound at the top of the address space
    step(0, 1, 32'hFFFF_FFFF,  0, 0,  32'h1,        1,  1,  1, 0, RUN);
    step(0, 0, 32'h0,          0, 0,  32'hFFFF_FFFF, 0, 0,  1, 1, RUN);
    step(0, 0, 32'h0,          0, 0,  32'h0,        0,  0,  1, 1, RUN);

    repeat (2) @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
Fetch-side consumer of the execute-stage next-PC redirect (execute_Next_PC / select_execute_Next_PC).
- Owns the program counter and drives the instruction-memory address.
- Applies execute redirects and generates the squash (flush) controls for the F/D and D/X latches.
- Buffers a redirect that arrives while the whole pipeline is frozen.
- Keeps a saturating redirect performance counter.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
CNT_W, 16, width of redirect performance counter.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
execute_Next_PC  input  32  redirect target computed in execute.
select_execute_Next_PC  input  1  execute requests redirect this cycle.
stall_fetch  input  1  load-use hazard: hold PC and F/D, insert bubble into D/X.
stall_all  input  1  multicycle unit busy: freeze PC and all latches.
address_imem  output  32  current PC, drives instruction memory (word address).
fd_pc_plus_one  output  32  PC+1, captured by F/D latch.
flush_FD  output  1  load NOP into F/D on this edge.
flush_DX  output  1  load NOP into D/X on this edge.
pc_write_enable  output  1  PC register updates on this edge.
redirect_count  output  CNT_W  number of redirects applied, saturating.

Behaviour:
Reset:
- On the reset edge: PC <= RESET_PC, state <= RUN, pending target <= 0, redirect_count <= 0.
- While reset is high: flush_FD = flush_DX = 1 and pc_write_enable = 0.

PC arithmetic:
- fd_pc_plus_one = PC + 1, 32-bit, modulo 2^32 (0xFFFFFFFF + 1 = 0).
- address_imem = PC, no latency.

State RUN, priority order, evaluated combinationally each cycle:
1. stall_all=1 and select_execute_Next_PC=1 -> capture execute_Next_PC into the pending register; next state HOLD. pc_write_enable=0; no flush.
2. stall_all=1 and no redirect -> everything holds; all outputs except address_imem/fd_pc_plus_one are deasserted.
3. select_execute_Next_PC=1 -> PC <= execute_Next_PC. flush_FD=1, flush_DX=1, pc_write_enable=1, redirect_count increments. A redirect overrides stall_fetch.
4. stall_fetch=1 -> pc_write_enable=0, flush_DX=1, flush_FD=0.
5. Otherwise -> PC <= PC+1, pc_write_enable=1, no flush.

State HOLD:
- While stall_all=1: hold. New execute redirects are ignored, because the frozen execute instruction is the same one already captured.
- First cycle with stall_all=0: PC <= pending target; flush_FD=1, flush_DX=1; count increments; next state RUN. The live select_execute_Next_PC is ignored in this cycle.

Latency and counter:
- Redirect latency: exactly one edge from the select cycle (RUN) or from stall release (HOLD) to address_imem = target.
- redirect_count saturates at 2^CNT_W-1 and does not wrap.

Mid-operation reset: reset in HOLD discards the pending target and returns to RUN at RESET_PC.

Decomposition:
- Shared processor package: RESET_PC default, NOP instruction constant (32'b0), state encoding (RUN=1'b0, HOLD=1'b1).
- One sub-module: register_32, a 32-bit register with write enable and synchronous reset value. It is instantiated for the PC and for the pending target.

Test Plan:
1. Reset, then run 3 cycles with no stalls -> address_imem 0,1,2,3; fd_pc_plus_one 1,2,3,4; no flushes.
2. At PC=5, assert select=1 with execute_Next_PC=0x40 for one cycle -> flush_FD=flush_DX=1 that cycle; next cycle address_imem=0x40; redirect_count=1.
3. stall_fetch=1 for 2 cycles at PC=7 -> PC stays 7; flush_DX=1, flush_FD=0 for both cycles; then PC advances to 8.
4. stall_fetch=1 together with select=1 (target 0x10) -> redirect wins; next PC=0x10; both flushes asserted.
5. stall_all=1 for 3 cycles with select=1 (target 0x80) in the first; in cycle 2 present select=1 with target 0x99 -> PC frozen throughout. First cycle after release: flushes asserted; next PC=0x80, not 0x99; count +1.
6. Preload counter near saturation (CNT_W=2), apply 5 redirects -> count stays at 3. Assert reset during HOLD -> PC=0, pending target discarded, state RUN.
